// File: rtl/mem_stage_pkg.sv
// Shared types for the MIPS memory stage: FSM states, alignment mask and
// the MEM/WB pipeline record.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1
    } mem_state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] readdata;
        logic [31:0] aluout;
        logic [4:0]  writereg;
        logic [31:0] instr;
    } mem_wb_t;

    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Word accesses only: both low address bits must be clear.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the prepared record every cycle or
// loads a bubble (all zeros) while the memory stage is still busy.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                bubble,
    input  logic [MEM_WB_W-1:0] d,
    output logic [MEM_WB_W-1:0] q
);

    // Capture or bubble on every clock; reset clears the whole record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage engine: issues data-memory accesses over a req/ack
// handshake, stalls upstream stages while an access is outstanding,
// aborts on timeout and retires misaligned/aborted accesses as bubbles.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic [4:0]  writeregM,
    input  logic [31:0] instrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stallM,
    output logic        regwriteW,
    output logic        memtoregW,
    output logic [31:0] readdataW,
    output logic [31:0] aluoutW,
    output logic [4:0]  writeregW,
    output logic [31:0] instrW,
    output logic        mem_err
);

    import mem_stage_pkg::*;

    // Counter value seen in the last BUSY cycle allowed before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t state, state_next;
    logic [7:0] cnt;
    logic       mem_op;
    logic       start_acc;
    logic       err_next;
    logic       bubble;
    mem_wb_t    wb_d;
    mem_wb_t    wb_q;

    assign mem_op   = memtoregM | memwriteM;
    // Request is exactly "access outstanding", so reset drops it at once.
    assign dmem_req = (state == MS_BUSY);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= MS_IDLE;
        else
            state <= state_next;
    end

    // Next state, stall and the record offered to MEM/WB.
    always_comb begin
        state_next   = state;
        stallM       = 1'b0;
        bubble       = 1'b0;
        start_acc    = 1'b0;
        err_next     = 1'b0;
        wb_d.regwrite = regwriteM;
        wb_d.memtoreg = memtoregM;
        wb_d.readdata = '0;
        wb_d.aluout   = aluoutM;
        wb_d.writereg = writeregM;
        wb_d.instr    = instrM;
        case (state)
            MS_IDLE: begin
                if (mem_op) begin
                    if (is_aligned(aluoutM[1:0])) begin
                        stallM     = 1'b1;
                        bubble     = 1'b1;
                        start_acc  = 1'b1;
                        state_next = MS_BUSY;
                    end else begin
                        wb_d.regwrite = 1'b0;
                        wb_d.memtoreg = 1'b0;
                        err_next      = 1'b1;
                    end
                end
            end
            MS_BUSY: begin
                if (dmem_ack) begin
                    wb_d.readdata = dmem_we ? 32'h0 : dmem_rdata;
                    state_next    = MS_IDLE;
                end else if (cnt == CNT_LAST) begin
                    wb_d.regwrite = 1'b0;
                    wb_d.memtoreg = 1'b0;
                    err_next      = 1'b1;
                    state_next    = MS_IDLE;
                end else begin
                    stallM = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: state_next = MS_IDLE;
        endcase
    end

    // Access latches, saturating wait counter and registered error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_we    <= 1'b0;
            cnt        <= '0;
            mem_err    <= 1'b0;
        end else begin
            mem_err <= err_next;
            if (start_acc) begin
                dmem_addr  <= aluoutM;
                dmem_wdata <= writedataM;
                dmem_we    <= memwriteM;
                cnt        <= '0;
            end else if (state == MS_BUSY && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    mem_wb_reg u_mem_wb (
        .clk    (clk),
        .reset  (reset),
        .bubble (bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign regwriteW = wb_q.regwrite;
    assign memtoregW = wb_q.memtoreg;
    assign readdataW = wb_q.readdata;
    assign aluoutW   = wb_q.aluout;
    assign writeregW = wb_q.writereg;
    assign instrW    = wb_q.instr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed and random instruction
// streams, a reactive data-memory responder and a WB-side monitor.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwriteM, memtoregM, memwriteM;
    logic [31:0] aluoutM, writedataM, instrM;
    logic [4:0]  writeregM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stallM;
    logic        regwriteW, memtoregW;
    logic [31:0] readdataW, aluoutW, instrW;
    logic [4:0]  writeregW;
    logic        mem_err;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
        .instrM(instrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stallM(stallM),
        .regwriteW(regwriteW), .memtoregW(memtoregW), .readdataW(readdataW),
        .aluoutW(aluoutW), .writeregW(writeregW), .instrW(instrW),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mt;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] ins;
        int          stall;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          delay;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic resp_en = 1'b0;
    logic man_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outcome of one instruction from the stage's rules.
    task automatic issue(input logic rw, input logic mt, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic [31:0] ins,
                         input int delay, input logic [31:0] rd);
        exp_t  e;
        plan_t p;
        int    n;
        e.rw = rw; e.mt = mt; e.rd = 32'h0; e.alu = alu; e.wr = wr;
        e.ins = ins; e.stall = 0; e.err = 1'b0;
        if ((mt || mw) && alu[1:0] != 2'b00) begin
            e.rw = 1'b0; e.mt = 1'b0; e.err = 1'b1;
        end else if (mt || mw) begin
            p.addr = alu; p.wdata = wd; p.we = mw; p.delay = delay; p.rdata = rd;
            plan_q.push_back(p);
            if (delay < TMO) begin
                e.stall = 1 + delay;
                if (mt) e.rd = rd;
            end else begin
                e.stall = TMO; e.rw = 1'b0; e.mt = 1'b0; e.err = 1'b1;
            end
        end
        exp_q.push_back(e);
        regwriteM = rw; memtoregM = mt; memwriteM = mw;
        aluoutM = alu; writedataM = wd; writeregM = wr; instrM = ins;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stallM === 1'b1 && n < TMO + 8);
        if (stallM === 1'b1) begin
            tests++; fails++;
            $display("FAIL stall_bound: stallM still 1 after %0d cycles, required release", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        regwriteM = 0; memtoregM = 0; memwriteM = 0;
        aluoutM = 0; writedataM = 0; writeregM = 0; instrM = 0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            idle_cycle();
            n++;
        end
        repeat (2) idle_cycle();
        chk("drain_exp_q", 32'(exp_q.size()), 32'h0);
        chk("drain_plan_q", 32'(plan_q.size()), 32'h0);
    endtask

    // Data-memory responder: acks each request after its planned delay.
    initial begin : responder
        plan_t cur;
        int    idx;
        logic  prev;
        dmem_ack = 1'b0; dmem_rdata = '0; prev = 1'b0; idx = 0;
        cur.addr = 0; cur.wdata = 0; cur.we = 0; cur.delay = 0; cur.rdata = 0;
        forever begin
            @(posedge clk); #2;
            if (!resp_en) begin
                dmem_ack = man_ack;
                dmem_rdata = $urandom;
            end else if (dmem_req) begin
                if (!prev) begin
                    if (plan_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_req: dmem_req=1 with addr %h, required no request", dmem_addr);
                        cur.delay = 0; cur.rdata = 0;
                    end else begin
                        cur = plan_q.pop_front();
                        chk("dmem_addr", dmem_addr, cur.addr);
                        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                        if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                    idx = 0;
                end
                if (idx == cur.delay) begin
                    dmem_ack = 1'b1; dmem_rdata = cur.rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                end
                idx++;
            end else begin
                dmem_ack = ($urandom_range(0, 7) == 0);
                dmem_rdata = $urandom;
            end
            prev = dmem_req;
        end
    end

    // WB monitor: every non-empty retirement is matched against the queue.
    initial begin : monitor
        int   scount;
        exp_t e;
        scount = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                scount = 0;
            end else begin
                if (instrW != 32'h0) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_retire: instrW=%h, required none", instrW);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instrW", instrW, e.ins);
                        chk("regwriteW", 32'(regwriteW), 32'(e.rw));
                        chk("memtoregW", 32'(memtoregW), 32'(e.mt));
                        chk("readdataW", readdataW, e.rd);
                        chk("aluoutW", aluoutW, e.alu);
                        chk("writeregW", 32'(writeregW), 32'(e.wr));
                        chk("mem_err", 32'(mem_err), 32'(e.err));
                        chk("stall_cycles", 32'(scount), 32'(e.stall));
                    end
                    scount = 0;
                end else begin
                    chk("idle_mem_err", 32'(mem_err), 32'h0);
                end
                if (stallM === 1'b1) scount++;
            end
        end
    end

    initial begin : main
        logic [31:0] a;
        int          kind;
        reset = 1'b1;
        regwriteM = 0; memtoregM = 0; memwriteM = 0;
        aluoutM = 0; writedataM = 0; writeregM = 0; instrM = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_dmem_we", 32'(dmem_we), 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_stallM", 32'(stallM), 32'h0);
        chk("rst_regwriteW", 32'(regwriteW), 32'h0);
        chk("rst_memtoregW", 32'(memtoregW), 32'h0);
        chk("rst_readdataW", readdataW, 32'h0);
        chk("rst_aluoutW", aluoutW, 32'h0);
        chk("rst_writeregW", 32'(writeregW), 32'h0);
        chk("rst_instrW", instrW, 32'h0);
        chk("rst_mem_err", 32'(mem_err), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1; resp_en = 1'b1;

        // Directed: add, load, store, misaligned, timeout, late-but-in-time ack.
        issue(1, 0, 0, 32'h5,   32'h0,    5'd8,  32'h0000_0020, 0, 32'h0);
        issue(1, 1, 0, 32'h100, 32'h0,    5'd9,  32'h8C00_0100, 0, 32'hDEADBEEF);
        issue(0, 0, 1, 32'h40,  32'h1234, 5'd3,  32'hAC00_0040, 3, 32'h5555_AAAA);
        issue(1, 1, 0, 32'h102, 32'h0,    5'd10, 32'h8C00_0102, 0, 32'h0);
        issue(1, 1, 0, 32'h200, 32'h0,    5'd11, 32'h8C00_0200, 99, 32'h0);
        issue(1, 1, 0, 32'h204, 32'h0,    5'd12, 32'h8C00_0204, TMO - 1, 32'hCAFE_F00D);
        idle_cycle();

        // Random mix of ALU ops, loads, stores, misalignment and idle slots.
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case (kind)
                0, 1: issue(1'($urandom), 0, 0, $urandom, $urandom, 5'($urandom),
                            $urandom | 32'h8000_0000, 0, 32'h0);
                2, 3: issue(1, 1, 0, a, $urandom, 5'($urandom), $urandom | 32'h8000_0000,
                            $urandom_range(0, TMO + 1), $urandom);
                4:    issue(0, 0, 1, a, $urandom, 5'($urandom), $urandom | 32'h8000_0000,
                            $urandom_range(0, TMO + 1), $urandom);
                default: idle_cycle();
            endcase
        end
        drain();

        // Reset in the second BUSY cycle of a load that is never acked.
        mon_en = 1'b0; resp_en = 1'b0; man_ack = 1'b0;
        regwriteM = 1; memtoregM = 1; memwriteM = 0;
        aluoutM = 32'h300; writeregM = 5'd7; instrM = 32'h8C00_0300;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_dmem_req", 32'(dmem_req), 32'h0);
        chk("midrst_regwriteW", 32'(regwriteW), 32'h0);
        chk("midrst_memtoregW", 32'(memtoregW), 32'h0);
        chk("midrst_readdataW", readdataW, 32'h0);
        chk("midrst_aluoutW", aluoutW, 32'h0);
        chk("midrst_writeregW", 32'(writeregW), 32'h0);
        chk("midrst_instrW", instrW, 32'h0);
        chk("midrst_dmem_addr", dmem_addr, 32'h0);
        regwriteM = 0; memtoregM = 0; aluoutM = 0; writeregM = 0; instrM = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        @(posedge clk); #3;
        chk("late_ack_req", 32'(dmem_req), 32'h0);
        chk("late_ack_instrW", instrW, 32'h0);
        chk("late_ack_regwriteW", 32'(regwriteW), 32'h0);
        chk("late_ack_mem_err", 32'(mem_err), 32'h0);
        chk("late_ack_stallM", 32'(stallM), 32'h0);
        exp_q.delete();
        plan_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1; resp_en = 1'b1;
        issue(1, 1, 0, 32'h300, 32'h0, 5'd7, 32'h8C00_0300, 1, 32'h1357_9BDF);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage engine of the 5-stage MIPS pipeline: consumes the MEM-stage control/data bundle driven by the EX/MEM register, performs the data-memory access over a req/ack handshake, stalls the upstream pipeline while the access is outstanding, and owns the MEM/WB pipeline register feeding write-back. Non-memory instructions pass through in one cycle. Misaligned and timed-out accesses retire as bubbles and raise an error pulse.

## Interface
- TIMEOUT_CYCLES, 255: max BUSY cycles waiting for dmem_ack before abort (1..255).
- clk  in  1  pipeline clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- regwriteM, memtoregM, memwriteM  in  1 each  MEM-stage controls; memtoregM=load, memwriteM=store (never both).
- aluoutM  in  32  effective address / ALU result.
- writedataM  in  32  store data.
- writeregM  in  5  destination register.
- instrM  in  32  instruction word (trace only).
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req.
- dmem_addr, dmem_wdata  out  32 each  latched address/store data.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  single-cycle completion strobe.
- stallM  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- regwriteW, memtoregW  out  1 each  MEM/WB controls.
- readdataW, aluoutW  out  32 each  load data / ALU result to WB.
- writeregW  out  5  WB destination.
- instrW  out  32  instruction in WB.
- mem_err  out  1  registered one-cycle error pulse.

## Operation
- FSM states: IDLE, BUSY (2-bit enum, no other states).
- IDLE, no mem op: stallM=0; MEM/WB captures inputs (readdataW=0).
- IDLE, mem op, aluoutM[1:0]==0: stallM=1; latch dmem_addr=aluoutM, dmem_wdata=writedataM, dmem_we=memwriteM; clear counter; -> BUSY; MEM/WB loads bubble.
- IDLE, mem op, aluoutM[1:0]!=0: no request, no stall; MEM/WB captures with regwriteW=0, memtoregW=0; mem_err=1 next cycle.
- BUSY: dmem_req=1; counter increments per cycle.
  - dmem_ack=1: stallM=0; MEM/WB captures inputs with readdataW=dmem_rdata (stores: readdataW=0); dmem_req=0 next cycle; -> IDLE.
  - no ack, counter==TIMEOUT_CYCLES-1: stallM=0; MEM/WB captures with regwriteW=0, memtoregW=0; mem_err=1 next cycle; -> IDLE.
  - else stallM=1; MEM/WB loads bubble.
- Bubble: regwriteW=0, memtoregW=0, instrW=0, writeregW=0, data fields 0.
- Ack and timeout same cycle: ack wins, no error.
- dmem_ack in IDLE ignored.
- Counter 8-bit, saturates; never wraps.

## Timing
- Reset values: state IDLE, counter 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, all *W outputs 0, mem_err 0; stallM=0 after reset.
- Non-memory instruction: MEM->WB in 1 cycle, zero stall.
- Memory op, ack at first BUSY cycle: 2 cycles MEM->WB, stallM high 1 cycle (IDLE cycle), low in ack cycle.
- General: stall cycles = 1 + (ack cycle index within BUSY, 0-based).
- Timeout: stallM high for TIMEOUT_CYCLES cycles total; instruction retires as bubble.
- Back-to-back memory ops: second starts in IDLE cycle right after ack; no dead cycle beyond stall rules.
- Reset mid-BUSY: immediate return to IDLE, dmem_req drops asynchronously, no WB write.

## Structure
- mem_stage_pkg: typedef enum mem_state_t {MS_IDLE, MS_BUSY}; localparam ALIGN_MASK=2'b11; typedef struct mem_wb_t {regwrite, memtoreg, readdata, aluout, writereg, instr}.
- One sub-module: mem_wb_reg — MEM/WB register with capture, bubble, async reset; FSM and handshake stay in mem_access_unit.

## Test plan
- Reset, then add (regwriteM=1, aluoutM=32'h5, writeregM=8) -> next cycle regwriteW=1, aluoutW=5, writeregW=8, stallM never 1.
- Load, aluoutM=32'h100, ack on first BUSY cycle with rdata=32'hDEADBEEF -> stallM high 1 cycle, dmem_addr=32'h100, dmem_we=0, then readdataW=32'hDEADBEEF, memtoregW=1.
- Store, aluoutM=32'h40, writedataM=32'h1234, ack after 3 BUSY cycles -> dmem_we=1, dmem_wdata=32'h1234, stallM high 4 cycles, regwriteW=0.
- Load aluoutM=32'h102 -> no dmem_req, no stall, mem_err pulse 1 cycle, regwriteW=0.
- TIMEOUT_CYCLES=4, load, no ack -> stallM high 4 cycles, dmem_req drops, mem_err pulse, regwriteW=0; ack on 4th BUSY cycle instead -> no error, data captured.
- Assert reset in 2nd BUSY cycle -> dmem_req=0, all *W=0 immediately; late ack ignored; next load proceeds normally.
